seq_mult_param: RTL and testbench

Parametrised sequential shift-add multiplier, the next generation of the team's fixed 4-bit combinational multiplier. It generalises operand width and adds a signed/unsigned mode. It also adds a start/busy/done handshake, trading one cycle per operand bit for a small adder. It sits in the datapath as a shared multiply resource fed by a controller.

---
 rtl/seq_mult_param_if.sv | 24 ++
 rtl/seq_mult_param.sv | 118 +++++++++++
 tb/tb_seq_mult_param.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seq_mult_param_if.sv
// Handshake and operand/product bus for the sequential shift-add multiplier.
// The controller drives the master side; the multiplier sits on the slave side.
interface seq_mult_param_if #(
  parameter int unsigned WIDTH = 4
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output start, is_signed, a, b,
    input  ready, busy, done, p
  );

  modport slave (
    input  start, is_signed, a, b,
    output ready, busy, done, p
  );
endinterface

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, with an optional
// signed mode handled as magnitude multiply plus a final conditional negate.
module seq_mult_param #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  seq_mult_param_if.slave bus
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sgn;
  logic [WIDTH-1:0] r_mcand;
  logic             r_neg;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_p;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_sum;
  logic [PW-1:0]    w_acc_nxt;
  logic [PW-1:0]    w_res;
  logic             w_last;

  assign w_accept = bus.start & r_ready;

  // r_sgn is forced low when signed mode is disabled, so the sign path folds away.
  assign w_a_neg = r_sgn & r_a[WIDTH-1];
  assign w_b_neg = r_sgn & r_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? WIDTH'(-r_a) : r_a;
  assign w_b_mag = w_b_neg ? WIDTH'(-r_b) : r_b;

  // Upper half plus multiplicand keeps the carry; lower half holds remaining multiplier bits.
  assign w_sum     = {1'b0, r_acc[PW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
  assign w_res     = r_neg ? PW'(-w_acc_nxt) : w_acc_nxt;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_mcand <= '0;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_sgn   <= bus.is_signed & SIGNED_EN;
            r_state <= S_LOAD;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          r_mcand <= w_a_mag;
          r_acc   <= {WIDTH'(0), w_b_mag};
          r_neg   <= w_a_neg ^ w_b_neg;
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_p     <= w_res;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.p     = r_p;
endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: a WIDTH=4 signed-capable instance and a
// WIDTH=8 unsigned-only instance, checked against hand-computed products.
module tb_seq_mult_param;
  logic clk = 1'b0;
  logic rst;
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  seq_mult_param_if #(.WIDTH(4)) m4 ();
  seq_mult_param_if #(.WIDTH(8)) m8 ();

  seq_mult_param #(.WIDTH(4), .SIGNED_EN(1'b1)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (m4)
  );

  seq_mult_param #(.WIDTH(8), .SIGNED_EN(1'b0)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (m8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic sgn, input logic [7:0] exp);
    int unsigned cyc;
    int unsigned nbusy;
    cyc   = 0;
    nbusy = 0;
    @(negedge clk);
    chk({tag, " ready"}, 32'(m4.ready), 32'd1);
    m4.start = 1'b1; m4.a = a; m4.b = b; m4.is_signed = sgn;
    @(negedge clk);
    m4.start = 1'b0;
    cyc = 1;
    while (!m4.done && cyc < 20) begin
      if (m4.busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, 32'd6);
    chk({tag, " busy_cycles"}, nbusy, 32'd5);
    chk({tag, " p"}, 32'(m4.p), 32'(exp));
    @(negedge clk);
    chk({tag, " done_width"}, 32'(m4.done), 32'd0);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp);
    int unsigned cyc;
    cyc = 0;
    @(negedge clk);
    m8.start = 1'b1; m8.a = a; m8.b = b; m8.is_signed = 1'b1;
    @(negedge clk);
    m8.start = 1'b0;
    cyc = 1;
    while (!m8.done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, 32'd10);
    chk({tag, " p"}, 32'(m8.p), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned nbusy;
    int unsigned t;
    logic [3:0] ea;
    logic [3:0] eb;

    rst = 1'b1;
    m4.start = 1'b0; m4.is_signed = 1'b0; m4.a = '0; m4.b = '0;
    m8.start = 1'b0; m8.is_signed = 1'b0; m8.a = '0; m8.b = '0;
    repeat (2) @(negedge clk);
    chk("rst4 ready", 32'(m4.ready), 32'd1);
    chk("rst4 busy",  32'(m4.busy),  32'd0);
    chk("rst4 done",  32'(m4.done),  32'd0);
    chk("rst4 p",     32'(m4.p),     32'd0);
    chk("rst8 ready", 32'(m8.ready), 32'd1);
    chk("rst8 p",     32'(m8.p),     32'd0);
    rst = 1'b0;

    // Unsigned directed vectors
    op4("u2x2",   4'd2,  4'd2,  1'b0, 8'h04);
    op4("u10x2",  4'd10, 4'd2,  1'b0, 8'h14);
    op4("u6x10",  4'd6,  4'd10, 1'b0, 8'h3C);
    op4("u11x3",  4'd11, 4'd3,  1'b0, 8'h21);
    op4("u15x3",  4'd15, 4'd3,  1'b0, 8'h2D);

    // Signed directed vectors, including most-negative squared and zero with neg sign
    op4("s-8x-8", 4'h8, 4'h8, 1'b1, 8'h40);
    op4("s-1x7",  4'hF, 4'h7, 1'b1, 8'hF9);
    op4("s7x-8",  4'h7, 4'h8, 1'b1, 8'hC8);
    op4("s0x-5",  4'h0, 4'hB, 1'b1, 8'h00);
    op4("s-3x-3", 4'hD, 4'hD, 1'b1, 8'h09);

    // start held high with operands changing while busy
    @(negedge clk);
    m4.start = 1'b1; m4.a = 4'd5; m4.b = 4'd3; m4.is_signed = 1'b0;
    @(negedge clk);
    cyc   = 1;
    nbusy = 0;
    while (!m4.done && cyc < 20) begin
      if (m4.busy) nbusy++;
      chk("hold prev p", 32'(m4.p), 32'h09);
      m4.a = 4'(cyc * 3 + 1);
      m4.b = 4'(cyc + 7);
      @(negedge clk);
      cyc++;
    end
    m4.start = 1'b0;
    chk("held latency", cyc, 32'd6);
    chk("held busy_cycles", nbusy, 32'd5);
    chk("held p", 32'(m4.p), 32'h0F);
    @(negedge clk);
    chk("held done_width", 32'(m4.done), 32'd0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    m4.start = 1'b1; m4.a = 4'd7; m4.b = 4'd5;
    @(negedge clk);
    m4.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-rst busy", 32'(m4.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst ready", 32'(m4.ready), 32'd1);
    chk("midrst busy",  32'(m4.busy),  32'd0);
    chk("midrst done",  32'(m4.done),  32'd0);
    chk("midrst p",     32'(m4.p),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    op4("post-rst 9x9", 4'd9, 4'd9, 1'b0, 8'h51);

    // Exhaustive unsigned sweep with back-to-back starts
    @(negedge clk);
    m4.start = 1'b1; m4.a = '0; m4.b = '0; m4.is_signed = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ea = 4'(i >> 4);
      eb = 4'(i);
      @(negedge clk);
      chk("sweep b2b busy", 32'(m4.busy), 32'd1);
      t = 0;
      while (!m4.done && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("sweep latency", t, 32'd5);
      chk("sweep p", 32'(m4.p), 32'(ea) * 32'(eb));
      if (i < 255) begin
        m4.a = 4'((i + 1) >> 4);
        m4.b = 4'(i + 1);
      end else begin
        m4.start = 1'b0;
      end
    end
    @(negedge clk);
    chk("sweep end done", 32'(m4.done), 32'd0);

    // WIDTH=8, signed mode disabled: is_signed must be ignored
    op8("w8 255x255", 8'hFF, 8'hFF, 16'hFE01);
    op8("w8 128x2",   8'h80, 8'h02, 16'h0100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
